// File: rtl/instr_assembler_pkg.sv
// Shared encodings for the instruction assembler: commands, addressing modes
// and the queued bundle format.
package instr_assembler_pkg;

    localparam int CW = 6;
    localparam int AW = 4;

    // Order matters: groups are indexed by opcode[7:5] from their first member.
    typedef enum logic [CW-1:0] {
        C_NOP, C_ORA, C_AND, C_EOR, C_ADC, C_STA, C_LDA, C_CMP, C_SBC,
        C_ASL, C_ROL, C_LSR, C_ROR, C_STX, C_LDX, C_DEC, C_INC,
        C_BPL, C_BMI, C_BVC, C_BVS, C_BCC, C_BCS, C_BNE, C_BEQ,
        C_BRK, C_JSR, C_RTI, C_RTS, C_BIT, C_JMP, C_STY, C_LDY, C_CPY, C_CPX,
        C_PHP, C_PLP, C_PHA, C_PLA, C_DEY, C_TAY, C_INY, C_INX,
        C_CLC, C_SEC, C_CLI, C_SEI, C_TYA, C_CLV, C_CLD, C_SED,
        C_TXA, C_TAX, C_DEX, C_TXS, C_TSX
    } cmd_e;

    typedef enum logic [AW-1:0] {
        A_IMPL, A_ACC, A_IMM, A_ZPG, A_ZPGX, A_ZPGY, A_XIND, A_INDY,
        A_REL, A_ABS, A_ABSX, A_ABSY, A_IND
    } addr_e;

    localparam cmd_e  CMD_NOP   = C_NOP;
    localparam addr_e ADDR_IMPL = A_IMPL;

    typedef struct packed {
        logic [7:0] opcode;
        cmd_e       cmd;
        addr_e      addr;
        logic [7:0] op_lo;
        logic [7:0] op_hi;
        logic [1:0] len;
        logic       illegal;
    } bundle_t;

    function automatic logic [1:0] addr_opcnt(input addr_e a);
        case (a)
            A_IMPL, A_ACC:                  return 2'd0;
            A_ABS, A_ABSX, A_ABSY, A_IND:   return 2'd2;
            default:                        return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/instr_assembler_op_class_decode.sv
// Combinational opcode classifier: command, addressing mode, operand count and
// illegal-opcode trap, following the aaa/bbb/cc opcode field layout.
module op_class_decode
    import instr_assembler_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic [7:0]    opcode_i,
    output logic [CW-1:0] cmd_o,
    output logic [AW-1:0] addr_o,
    output logic [1:0]    opcnt_o,
    output logic          illegal_o
);
    logic [2:0] aaa, bbb;
    logic [1:0] cc;
    cmd_e       cmd;
    addr_e      addr;
    logic       illegal;

    always_comb begin
        aaa     = opcode_i[7:5];
        bbb     = opcode_i[4:2];
        cc      = opcode_i[1:0];
        cmd     = CMD_NOP;
        addr    = ADDR_IMPL;
        illegal = 1'b0;
        if (cc == 2'b11) begin
            if (ILLEGAL_TRAP != 0) illegal = 1'b1;
            else                   cc = 2'b10;
        end
        if (!illegal) begin
            case (cc)
                2'b01: begin
                    cmd = cmd_e'(CW'(C_ORA) + CW'(aaa));
                    case (bbb)
                        3'd0: addr = A_XIND;
                        3'd1: addr = A_ZPG;
                        3'd2: addr = A_IMM;
                        3'd3: addr = A_ABS;
                        3'd4: addr = A_INDY;
                        3'd5: addr = A_ZPGX;
                        3'd6: addr = A_ABSY;
                        default: addr = A_ABSX;
                    endcase
                end
                2'b10: begin
                    cmd = cmd_e'(CW'(C_ASL) + CW'(aaa));
                    case (bbb)
                        // Group-2 immediate slot is only legal for LDX.
                        3'd0: begin addr = A_IMM; cmd = C_LDX; end
                        3'd1: addr = A_ZPG;
                        3'd2: begin
                            if (!aaa[2])       addr = A_ACC;
                            else if (aaa == 3'd7) cmd = C_NOP;
                            else               cmd = cmd_e'(CW'(C_TXA) + CW'(aaa[1:0]));
                        end
                        3'd3: addr = A_ABS;
                        3'd5: addr = (aaa == 3'd4 || aaa == 3'd5) ? A_ZPGY : A_ZPGX;
                        3'd6: cmd = (aaa == 3'd4) ? C_TXS : (aaa == 3'd5) ? C_TSX : C_NOP;
                        3'd7: addr = (aaa == 3'd5) ? A_ABSY : A_ABSX;
                        default: cmd = C_NOP;
                    endcase
                end
                default: begin
                    case (bbb)
                        3'd0: begin
                            case (aaa)
                                3'd0: cmd = C_BRK;
                                3'd1: begin cmd = C_JSR; addr = A_ABS; end
                                3'd2: cmd = C_RTI;
                                3'd3: cmd = C_RTS;
                                3'd4: addr = A_IMM;
                                3'd5: begin cmd = C_LDY; addr = A_IMM; end
                                3'd6: begin cmd = C_CPY; addr = A_IMM; end
                                default: begin cmd = C_CPX; addr = A_IMM; end
                            endcase
                        end
                        3'd2: cmd = cmd_e'(CW'(C_PHP) + CW'(aaa));
                        3'd4: begin cmd = cmd_e'(CW'(C_BPL) + CW'(aaa)); addr = A_REL; end
                        3'd6: cmd = cmd_e'(CW'(C_CLC) + CW'(aaa));
                        default: begin
                            case (aaa)
                                3'd0: cmd = C_NOP;
                                3'd1: cmd = C_BIT;
                                3'd2, 3'd3: cmd = C_JMP;
                                3'd4: cmd = C_STY;
                                3'd5: cmd = C_LDY;
                                3'd6: cmd = C_CPY;
                                default: cmd = C_CPX;
                            endcase
                            case (bbb)
                                3'd1: addr = A_ZPG;
                                3'd3: addr = (aaa == 3'd3) ? A_IND : A_ABS;
                                3'd5: addr = A_ZPGX;
                                default: addr = A_ABSX;
                            endcase
                        end
                    endcase
                end
            endcase
        end
        cmd_o     = cmd;
        addr_o    = addr;
        illegal_o = illegal;
        opcnt_o   = (opcode_i == 8'h20) ? 2'd2 : addr_opcnt(addr);
    end

endmodule

// File: rtl/instr_assembler.sv
// Collects opcode/operand bytes into instruction bundles and queues them for a
// downstream consumer with valid/ready handshakes on both sides.
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int CMD_W        = 6,
    parameter int ADDR_W       = 4,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_opcode,
    output logic [CMD_W-1:0]  out_cmd,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_op_lo,
    output logic [7:0]        out_op_hi,
    output logic [1:0]        out_len,
    output logic              out_illegal
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_OPC, S_LO, S_HI} state_e;

    state_e              state_q, state_d;
    logic [7:0]          opc_q, opc_d, lo_q, lo_d, hi_q, hi_d;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    cnt_q;
    bundle_t             mem_q [FIFO_DEPTH];
    bundle_t             push_b, head;
    logic                full, accept, push, pop;
    logic [CW-1:0]       dec_cmd;
    logic [AW-1:0]       dec_addr;
    logic [1:0]          dec_cnt;
    logic                dec_ill;

    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign in_ready  = !full && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready && !flush;

    // Later operand bytes re-decode the held opcode.
    op_class_decode #(.ILLEGAL_TRAP(ILLEGAL_TRAP)) u_dec (
        .opcode_i  ((state_q == S_OPC) ? in_byte : opc_q),
        .cmd_o     (dec_cmd),
        .addr_o    (dec_addr),
        .opcnt_o   (dec_cnt),
        .illegal_o (dec_ill)
    );

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        push    = 1'b0;
        if (accept) begin
            case (state_q)
                S_OPC: begin
                    opc_d = in_byte;
                    lo_d  = 8'h00;
                    hi_d  = 8'h00;
                    if (dec_cnt == 2'd0) push = 1'b1;
                    else                 state_d = S_LO;
                end
                S_LO: begin
                    lo_d = in_byte;
                    if (dec_cnt == 2'd1) begin
                        push    = 1'b1;
                        state_d = S_OPC;
                    end else begin
                        state_d = S_HI;
                    end
                end
                default: begin
                    hi_d    = in_byte;
                    push    = 1'b1;
                    state_d = S_OPC;
                end
            endcase
        end
        push_b = '{opcode: opc_d, cmd: cmd_e'(dec_cmd), addr: addr_e'(dec_addr),
                   op_lo: lo_d, op_hi: hi_d, len: dec_cnt + 2'd1, illegal: dec_ill};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= S_OPC;
            opc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            if (push) begin
                mem_q[wptr_q] <= push_b;
                wptr_q <= (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            if (pop)
                rptr_q <= (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Empty queue presents an all-zero bundle.
    assign head        = out_valid ? mem_q[rptr_q] : '0;
    assign out_opcode  = head.opcode;
    assign out_cmd     = CMD_W'(head.cmd);
    assign out_addr    = ADDR_W'(head.addr);
    assign out_op_lo   = head.op_lo;
    assign out_op_hi   = head.op_hi;
    assign out_len     = head.len;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed self-checking bench for instr_assembler (trap and no-trap builds).
module tb_instr_assembler;
    import instr_assembler_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready, out_valid, out_illegal;
    logic [7:0] out_opcode, out_op_lo, out_op_hi;
    logic [5:0] out_cmd;
    logic [3:0] out_addr;
    logic [1:0] out_len;

    logic       in_valid1 = 1'b0;
    logic [7:0] in_byte1 = 8'h00;
    logic       in_ready1, out_valid1, out_illegal1;
    logic [7:0] out_opcode1, out_op_lo1, out_op_hi1;
    logic [5:0] out_cmd1;
    logic [3:0] out_addr1;
    logic [1:0] out_len1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_assembler #(.FIFO_DEPTH(2), .CMD_W(6), .ADDR_W(4), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_cmd(out_cmd), .out_addr(out_addr),
        .out_op_lo(out_op_lo), .out_op_hi(out_op_hi), .out_len(out_len),
        .out_illegal(out_illegal)
    );

    instr_assembler #(.FIFO_DEPTH(2), .CMD_W(6), .ADDR_W(4), .ILLEGAL_TRAP(0)) dut1 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid1), .in_byte(in_byte1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(1'b1),
        .out_opcode(out_opcode1), .out_cmd(out_cmd1), .out_addr(out_addr1),
        .out_op_lo(out_op_lo1), .out_op_hi(out_op_hi1), .out_len(out_len1),
        .out_illegal(out_illegal1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL send_byte_timeout: in_ready=%0b want 1 for byte %h", in_ready, b);
            errors++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_bundle(input string name, input logic [7:0] opc, input logic [5:0] cmd,
                                input logic [3:0] addr, input logic [7:0] lo, input logic [7:0] hi,
                                input logic [1:0] len, input logic ill);
        checks++;
        if (out_valid !== 1'b1 || out_opcode !== opc || out_cmd !== cmd || out_addr !== addr ||
            out_op_lo !== lo || out_op_hi !== hi || out_len !== len || out_illegal !== ill) begin
            $display("FAIL %s: got v=%0b opc=%h cmd=%0d addr=%0d lo=%h hi=%h len=%0d ill=%0b want v=1 opc=%h cmd=%0d addr=%0d lo=%h hi=%h len=%0d ill=%0b",
                     name, out_valid, out_opcode, out_cmd, out_addr, out_op_lo, out_op_hi, out_len,
                     out_illegal, opc, cmd, addr, lo, hi, len, ill);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL reset_hs: in_ready=%0b out_valid=%0b want 0 0", in_ready, out_valid);
            errors++;
        end
        checks++;
        if (out_opcode !== 8'h00 || out_cmd !== 6'd0 || out_len !== 2'd0 || out_op_lo !== 8'h00) begin
            $display("FAIL reset_fields: opc=%h cmd=%0d len=%0d lo=%h want all 0",
                     out_opcode, out_cmd, out_len, out_op_lo);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release: in_ready=%0b want 1", in_ready);
            errors++;
        end
    endtask

    task automatic test_immediate();
        out_ready = 1'b1;
        send_byte(8'hA9);
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL imm_early: out_valid=%0b want 0", out_valid);
            errors++;
        end
        send_byte(8'h42);
        check_bundle("imm_lda", 8'hA9, C_LDA, A_IMM, 8'h42, 8'h00, 2'd2, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL imm_single: out_valid=%0b want 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_three_byte();
        out_ready = 1'b1;
        send_byte(8'h20);
        send_byte(8'h34);
        send_byte(8'h12);
        check_bundle("jsr", 8'h20, C_JSR, A_ABS, 8'h34, 8'h12, 2'd3, 1'b0);
        tick();
        send_byte(8'hAD);
        send_byte(8'h00);
        send_byte(8'hC0);
        check_bundle("lda_abs", 8'hAD, C_LDA, A_ABS, 8'h00, 8'hC0, 2'd3, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_byte(8'hEA);
        send_byte(8'hEA);
        in_valid = 1'b1;
        in_byte  = 8'hEA;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL full_block: in_ready=%0b want 0", in_ready);
            errors++;
        end
        tick();
        tick();
        check_bundle("full_head", 8'hEA, C_NOP, A_IMPL, 8'h00, 8'h00, 2'd1, 1'b0);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL no_comb_path: in_ready=%0b want 0", in_ready);
            errors++;
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL after_pop: in_ready=%0b want 1", in_ready);
            errors++;
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL third_taken: in_ready=%0b out_valid=%0b want 0 1", in_ready, out_valid);
            errors++;
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL drain: out_valid=%0b want 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_byte(8'hAD);
        send_byte(8'h00);
        in_valid = 1'b1;
        in_byte  = 8'hE8;
        flush    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL flush_ready: in_ready=%0b want 0", in_ready);
            errors++;
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_empty: out_valid=%0b want 0", out_valid);
            errors++;
        end
        send_byte(8'hE8);
        check_bundle("flush_inx", 8'hE8, C_INX, A_IMPL, 8'h00, 8'h00, 2'd1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL flush_single: out_valid=%0b want 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send_byte(8'h03);
        check_bundle("trap_03", 8'h03, C_NOP, A_IMPL, 8'h00, 8'h00, 2'd1, 1'b1);
        tick();
        in_valid1 = 1'b1;
        in_byte1  = 8'h03;
        tick();
        checks++;
        if (out_valid1 !== 1'b0) begin
            $display("FAIL notrap_early: out_valid=%0b want 0", out_valid1);
            errors++;
        end
        in_byte1 = 8'h55;
        tick();
        in_valid1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b1 || out_cmd1 !== C_LDX || out_addr1 !== A_IMM || out_len1 !== 2'd2 ||
            out_op_lo1 !== 8'h55 || out_illegal1 !== 1'b0 || out_opcode1 !== 8'h03) begin
            $display("FAIL notrap_ldx: got v=%0b opc=%h cmd=%0d addr=%0d len=%0d lo=%h ill=%0b want v=1 opc=03 cmd=%0d addr=%0d len=2 lo=55 ill=0",
                     out_valid1, out_opcode1, out_cmd1, out_addr1, out_len1, out_op_lo1, out_illegal1,
                     C_LDX, A_IMM);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_byte(8'h20);
        send_byte(8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_mid_empty: out_valid=%0b want 0", out_valid);
            errors++;
        end
        send_byte(8'hEA);
        check_bundle("rst_mid_nop", 8'hEA, C_NOP, A_IMPL, 8'h00, 8'h00, 2'd1, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_three_byte();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 2, bundle queue entries (>=1, any integer); CMD_W, default 6, cmd width; ADDR_W, default 4, addressing-mode width; ILLEGAL_TRAP, default 1, 1 = trap c==2'b11 opcodes.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, rising edge;
 rst  in  1  synchronous reset, active-high;
 flush  in  1  discard partial instruction and queued bundles;
 in_valid  in  1  byte available;
 in_byte  in  8  fetched instruction byte;
 in_ready  out  1  byte accepted when in_valid&&in_ready;
 out_valid  out  1  bundle at queue head;
 out_ready  in  1  consumer takes bundle when out_valid&&out_ready;
 out_opcode  out  8  opcode byte;
 out_cmd  out  CMD_W  decoded command;
 out_addr  out  ADDR_W  decoded addressing mode;
 out_op_lo  out  8  first operand byte, 0 if absent;
 out_op_hi  out  8  second operand byte, 0 if absent;
 out_len  out  2  total bytes 1..3;
 out_illegal  out  1  opcode trapped.

Function
REQ-003 SHALL run FSM S_OPC -> S_LO -> S_HI, advancing only on accepted bytes.
REQ-004 S_OPC: accepted byte is latched as opcode and decoded; operand count 0 -> bundle pushed same edge, stay S_OPC; else -> S_LO.
REQ-005 S_LO: byte latched as op_lo; count 1 -> push, S_OPC; count 2 -> S_HI. S_HI: byte latched as op_hi, push, S_OPC.
REQ-006 Operand count by mode: impl, A -> 0; IMMEDIATE, zpg, zpgX, zpgY, Xind, indY, rel -> 1; abs, absX, absY, ind -> 2; override opcode 0x20 (JSR) -> 2.
REQ-007 ILLEGAL_TRAP=1 and opcode[1:0]==2'b11 -> cmd=NOP, addr=impl, count 0, out_illegal=1; ILLEGAL_TRAP=0 -> decode as opcode[1:0]==2'b10, out_illegal=0.
REQ-008 in_ready SHALL equal !full && !flush && !rst; no combinational path from out_ready to in_ready.
REQ-009 Push-time full is impossible (final byte only accepted when not full).
REQ-010 Latency: out_valid asserts the cycle after the final byte is accepted (queue empty case).
REQ-011 out_valid = (count != 0); outputs driven from queue head, stable while out_valid && !out_ready.
REQ-012 Simultaneous push and pop SHALL keep count unchanged; read/write pointers wrap FIFO_DEPTH-1 -> 0.
REQ-013 flush SHALL, at the edge, empty queue, return FSM to S_OPC, clear partial fields; pop during flush ignored; flush overrides in_valid.

Reset
REQ-014 rst SHALL set FSM S_OPC, count 0, pointers 0, latched opcode/op_lo/op_hi 0; outputs: in_ready 0 during rst, out_valid 0, out_* bundle fields 0.
REQ-015 rst mid-instruction SHALL drop partial bytes; first accepted byte after rst is an opcode.

Structure
REQ-016 cmd and addressing-mode encodings and NOP/impl constants SHALL come from the shared parameter file; no local redefinition.
REQ-017 Bundle SHALL be a packed struct in the shared package (opcode, cmd, addr, op_lo, op_hi, len, illegal).
REQ-018 One sub-module op_class_decode: combinational opcode -> {cmd, addr, operand count, illegal}, parameter ILLEGAL_TRAP.

Verification
REQ-019 Stream A9,42, out_ready=1 -> one bundle LDA/IMMEDIATE, op_lo 42, op_hi 00, len 2, out_valid the cycle after 42 accepted.
REQ-020 Stream 20,34,12 -> JSR, len 3, op_lo 34, op_hi 12; AD,00,C0 -> LDA/abs, len 3.
REQ-021 FIFO_DEPTH=2, out_ready=0, stream EA,EA,EA -> two NOP bundles queued, in_ready 0 with third EA held; one pop -> in_ready 1 next cycle, third accepted.
REQ-022 AD,00 then flush, then E8 -> no AD bundle; single INX/impl bundle, len 1.
REQ-023 Byte 03: ILLEGAL_TRAP=1 -> NOP, illegal 1, len 1; ILLEGAL_TRAP=0 -> LDX/IMMEDIATE, len 2, next byte as op_lo.
REQ-024 rst asserted after 20,34 -> no bundle; post-reset EA -> NOP, len 1.
